// File: rtl/video_timing_ctrl_pkg.sv
// Shared timing defaults, coordinate width and sequencer state encoding
// for the 640x480@60 raster sequencer.
package video_timing_ctrl_pkg;

    localparam int unsigned CW = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic [23:0] UF_COLOR_DEF = 24'hFF00FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vt_state_e;

    // Physical pin level for a sync pulse given its logical assertion.
    function automatic logic sync_level(input logic asserted, input logic neg);
        return asserted ^ neg;
    endfunction

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Pixel request/return handshake between the raster sequencer (master)
// and the upstream pixel source (slave).
interface video_timing_ctrl_if;
    import video_timing_ctrl_pkg::*;

    logic          pix_req;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          src_valid;
    logic [7:0]    src_r;
    logic [7:0]    src_g;
    logic [7:0]    src_b;

    modport master (
        output pix_req, x, y,
        input  src_valid, src_r, src_g, src_b
    );

    modport slave (
        input  pix_req, x, y,
        output src_valid, src_r, src_g, src_b
    );

endinterface

// File: rtl/video_hv_counter.sv
// Horizontal/vertical raster position counters with wrap, clear-to-origin
// and an end-of-frame flag at the last pixel of the last line.
module video_hv_counter
    import video_timing_ctrl_pkg::*;
#(
    parameter int unsigned H_TOTAL = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v,
    output logic          eof
);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Advance h every enabled cycle, v on h wrap; clear forces the origin.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (clr) begin
            h_d = '0;
            v_d = '0;
        end else if (en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    assign h   = h_q;
    assign v   = v_q;
    assign eof = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer feeding hdmi_tx: counters (stage 0), pixel request
// (stage 1) and aligned sync/de/RGB output (stage 2), with a run/drain FSM
// that only starts and stops on frame boundaries and underflow reporting.
module video_timing_ctrl
    import video_timing_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          SYNC_NEG = 1'b1,
    parameter logic [23:0] UF_COLOR = UF_COLOR_DEF
) (
    input  logic                pix_clk,
    input  logic                rst,
    input  logic                enable,
    video_timing_ctrl_if.master src,
    output logic [7:0]          red,
    output logic [7:0]          green,
    output logic [7:0]          blue,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic                frame_start,
    output logic                running,
    output logic                underflow,
    output logic [15:0]         uf_count,
    input  logic                uf_clr
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_L = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_L = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_IDLE = sync_level(1'b0, SYNC_NEG);

    // ---------------- stage 0: FSM and counters ----------------
    vt_state_e state_q, state_d;
    logic [CW-1:0] h, v;
    logic          eof;
    logic          live;

    assign live = (state_q != ST_IDLE);

    video_hv_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_hv (
        .clk (pix_clk),
        .rst (rst),
        .en  (live),
        .clr (!live),
        .h   (h),
        .v   (v),
        .eof (eof)
    );

    // Sequencer state register.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: stopping is deferred until the last pixel of the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)   state_d = ST_RUN;
                else if (eof) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- stage 1: pixel request ----------------
    logic          pix_req_q, pix_req_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;

    // Request registers, plus sync/frame markers carried alongside so that
    // stage 2 emits them in the same cycle as the matching pixel.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            pix_req_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            fs1_q     <= 1'b0;
        end else begin
            pix_req_q <= pix_req_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            fs1_q     <= fs1_d;
        end
    end

    // Decode the counter position into request, coordinates and sync windows.
    always_comb begin
        pix_req_d = live && (h < H_ACT_L) && (v < V_ACT_L);
        x_d       = pix_req_d ? h : '0;
        y_d       = pix_req_d ? v : '0;
        hs1_d     = live && (h >= HS_BEG) && (h < HS_END);
        vs1_d     = live && (v >= VS_BEG) && (v < VS_END);
        fs1_d     = pix_req_d && (h == '0) && (v == '0);
    end

    assign src.pix_req = pix_req_q;
    assign src.x       = x_q;
    assign src.y       = y_q;

    // ---------------- stage 2: video output ----------------
    logic        de_q, de_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;
    logic        uf_q, uf_d;
    logic [15:0] ufc_q, ufc_d;
    logic        uf_event;

    // Output registers, sync pins idle at their inactive level.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            de_q    <= 1'b0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
            uf_q    <= 1'b0;
            ufc_q   <= '0;
        end else begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
            uf_q    <= uf_d;
            ufc_q   <= ufc_d;
        end
    end

    // Select source, substitute or blank pixel; an underflow event takes
    // priority over a simultaneous clear so the new event is never lost.
    always_comb begin
        uf_event = pix_req_q && !src.src_valid;
        de_d     = pix_req_q;
        hsync_d  = sync_level(hs1_q, SYNC_NEG);
        vsync_d  = sync_level(vs1_q, SYNC_NEG);
        fs_d     = fs1_q;
        rgb_d    = '0;
        if (pix_req_q) rgb_d = src.src_valid ? {src.src_r, src.src_g, src.src_b} : UF_COLOR;
        uf_d  = uf_q;
        ufc_d = ufc_q;
        if (uf_event) begin
            uf_d  = 1'b1;
            if (uf_clr)           ufc_d = 16'd1;
            else if (ufc_q != '1) ufc_d = ufc_q + 16'd1;
        end else if (uf_clr) begin
            uf_d  = 1'b0;
            ufc_d = '0;
        end
    end

    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
    assign running     = live;
    assign underflow   = uf_q;
    assign uf_count    = ufc_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a reduced 16x8 raster (8x4 active) so whole
// frames, drain, re-enable and mid-frame reset fit in a short run. A second
// instance with SYNC_NEG=0 shares clock, reset and enable.
module tb_video_timing_ctrl;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FR = HT * VT;

    logic pix_clk = 1'b0;
    logic rst, enable, uf_clr;
    logic uf_en, uf_one;

    always #5 pix_clk = ~pix_clk;

    video_timing_ctrl_if sa ();
    video_timing_ctrl_if sb ();

    // Source A: ramp data, combinational from the requested coordinates;
    // valid is withheld on selected pixels to provoke underflow.
    assign sa.src_r     = sa.x[7:0];
    assign sa.src_g     = sa.y[7:0];
    assign sa.src_b     = 8'hA5;
    assign sa.src_valid = !((uf_en && sa.y == 10'd1 && sa.x >= 10'd2 && sa.x < 10'd7) ||
                            (uf_one && sa.y == 10'd2 && sa.x == 10'd3));
    assign sb.src_r     = 8'h00;
    assign sb.src_g     = 8'h00;
    assign sb.src_b     = 8'h00;
    assign sb.src_valid = 1'b1;

    logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        hsync_a, vsync_a, de_a, fs_a, running_a, uf_a;
    logic        hsync_b, vsync_b, de_b, fs_b, running_b, uf_b;
    logic [15:0] ufc_a, ufc_b;

    video_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_NEG (1'b1), .UF_COLOR (24'hFF00FF)
    ) dut_a (
        .pix_clk (pix_clk), .rst (rst), .enable (enable), .src (sa.master),
        .red (red_a), .green (green_a), .blue (blue_a),
        .hsync (hsync_a), .vsync (vsync_a), .de (de_a), .frame_start (fs_a),
        .running (running_a), .underflow (uf_a), .uf_count (ufc_a), .uf_clr (uf_clr)
    );

    video_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_NEG (1'b0), .UF_COLOR (24'hFF00FF)
    ) dut_b (
        .pix_clk (pix_clk), .rst (rst), .enable (enable), .src (sb.master),
        .red (red_b), .green (green_b), .blue (blue_b),
        .hsync (hsync_b), .vsync (vsync_b), .de (de_b), .frame_start (fs_b),
        .running (running_b), .underflow (uf_b), .uf_count (ufc_b), .uf_clr (uf_clr)
    );

    int errors = 0;
    int checks = 0;
    int k = 0;          // sample index; k == base is the first cycle in RUN
    int base = 0;
    int end_pix = 0;    // pixels the run produces before returning to IDLE
    int run_id = 0;
    bit model_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Expected outputs from the raster position: pix_req shows the counter
    // value of the previous sample, de-stage outputs the one before that.
    task automatic check_cycle();
        int rel, q, r, qh, qv, rh, rv, rf;
        logic e_req, e_de, e_hs, e_vs, e_fs, e_uf;
        logic [7:0] er, eg, eb;
        rel = k - base;
        check("running", running_a, (rel >= 0 && rel < end_pix));
        check("running_b", running_b, (rel >= 0 && rel < end_pix));
        q = rel - 1; qh = 0; qv = 0; e_req = 1'b0;
        if (q >= 0 && q < end_pix) begin
            qh = q % HT; qv = (q / HT) % VT;
            e_req = (qh < 8) && (qv < 4);
        end
        check("pix_req", sa.pix_req, e_req);
        check("x", sa.x, e_req ? qh : 0);
        check("y", sa.y, e_req ? qv : 0);
        check("pix_req_b", sb.pix_req, e_req);
        r = rel - 2; rh = 0; rv = 0; rf = 0;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_uf = 1'b0;
        if (r >= 0 && r < end_pix) begin
            rh = r % HT; rv = (r / HT) % VT; rf = r / FR;
            e_de = (rh < 8) && (rv < 4);
            e_hs = (rh >= 10) && (rh < 13);
            e_vs = (rv >= 5) && (rv < 7);
            e_fs = (r % FR) == 0;
            e_uf = e_de && run_id == 1 &&
                   ((rf == 0 && rv == 1 && rh >= 2 && rh < 7) || (rf == 1 && rv == 2 && rh == 3));
        end
        er = 8'h00; eg = 8'h00; eb = 8'h00;
        if (e_uf) begin
            er = 8'hFF; eg = 8'h00; eb = 8'hFF;
        end else if (e_de) begin
            er = 8'(rh); eg = 8'(rv); eb = 8'hA5;
        end
        check("de", de_a, e_de);
        check("hsync", hsync_a, !e_hs);
        check("vsync", vsync_a, !e_vs);
        check("frame_start", fs_a, e_fs);
        check("red", red_a, er);
        check("green", green_a, eg);
        check("blue", blue_a, eb);
        check("de_b", de_b, e_de);
        check("hsync_b", hsync_b, e_hs);
        check("vsync_b", vsync_b, e_vs);
        check("frame_start_b", fs_b, e_fs);
        check("rgb_b", {red_b, green_b, blue_b}, 24'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_req"}, sa.pix_req, 1'b0);
        check({tag, "_x"}, sa.x, 0);
        check({tag, "_y"}, sa.y, 0);
        check({tag, "_de"}, de_a, 1'b0);
        check({tag, "_fs"}, fs_a, 1'b0);
        check({tag, "_running"}, running_a, 1'b0);
        check({tag, "_underflow"}, uf_a, 1'b0);
        check({tag, "_uf_count"}, ufc_a, 0);
        check({tag, "_rgb"}, {red_a, green_a, blue_a}, 24'h0);
        check({tag, "_hsync"}, hsync_a, 1'b1);
        check({tag, "_vsync"}, vsync_a, 1'b1);
        check({tag, "_hsync_b"}, hsync_b, 1'b0);
        check({tag, "_vsync_b"}, vsync_b, 1'b0);
        check({tag, "_de_b"}, de_b, 1'b0);
        check({tag, "_uf_b"}, {uf_b, ufc_b}, 0);
    endtask

    task automatic tick();
        @(posedge pix_clk);
        #1;
        k++;
        if (model_on) check_cycle();
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; uf_clr = 1'b0; uf_en = 1'b1; uf_one = 1'b0;
        repeat (3) tick();
        check_reset_vals("por");

        // Run 1: start, underflow burst, drain/re-enable, drain to IDLE.
        rst = 1'b0; enable = 1'b1;
        k = -1; base = 0; end_pix = 3 * FR; run_id = 1; model_on = 1'b1;

        run_to(130);
        uf_en = 1'b0; uf_one = 1'b1;
        run_to(164);
        check("uf_flag_5", uf_a, 1'b1);
        check("uf_count_5", ufc_a, 5);
        uf_clr = 1'b1;
        run_to(165);
        check("uf_flag_clr_evt", uf_a, 1'b1);
        check("uf_count_clr_evt", ufc_a, 1);
        run_to(166);
        check("uf_flag_cleared", uf_a, 1'b0);
        check("uf_count_cleared", ufc_a, 0);
        uf_clr = 1'b0;

        run_to(200);
        uf_one = 1'b0; enable = 1'b0;
        run_to(210);
        enable = 1'b1;
        run_to(293);
        enable = 1'b0;
        run_to(400);
        check("idle_uf_count", ufc_a, 0);

        // Run 2: restart from IDLE, then reset mid-frame at (5,2).
        enable = 1'b1; base = 401; end_pix = 1000000; run_id = 2;
        run_to(base + 37);
        model_on = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_async");
        repeat (3) tick();
        check_reset_vals("rst_held");

        // Run 3: release reset with enable held; clean frame from origin.
        rst = 1'b0; base = k + 1; run_id = 3; model_on = 1'b1;
        run_to(base + 135);
        check("final_underflow", uf_a, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
